controle_execucao: RTL and testbench

- Multi-cycle issue/execute controller that sits directly upstream of the 16-bit signed ALU.
- Accepts one 16-bit instruction per handshake and decodes it.
- Reads operands from an internal 16x16 register file, drives the ALU operands and opcode, captures the ALU's 17-bit result, and writes back.
- Publishes the written value plus a completion pulse to the display/top level.

---
 rtl/controle_execucao_pkg.sv | 59 +++++
 rtl/controle_execucao_if.sv | 21 ++
 rtl/controle_execucao_banco_registradores.sv | 35 +++
 rtl/controle_execucao.sv | 134 +++++++++++++
 tb/tb_controle_execucao.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/controle_execucao_pkg.sv
// Shared types for the issue/execute controller.
// Opcode values double as the ALU param encoding.
package ctrl_pkg;

  localparam int DATA_W = 16;
  localparam int NREG   = 16;
  localparam int AW     = 4;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int RD_MSB  = 12;
  localparam int RD_LSB  = 9;
  localparam int RS1_MSB = 8;
  localparam int RS1_LSB = 5;
  localparam int RS2_MSB = 4;
  localparam int RS2_LSB = 1;
  localparam int I5_MSB  = 4;
  localparam int I9_MSB  = 8;

  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_ADD  = 3'b001,
    OP_ADDI = 3'b010,
    OP_SUB  = 3'b011,
    OP_SUBI = 3'b100,
    OP_MUL  = 3'b101,
    OP_CLR  = 3'b110,
    OP_DISP = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    EXEC,
    WRITE
  } state_t;

  function automatic logic is_alu(input op_t op);
    return op inside {OP_ADD, OP_ADDI, OP_SUB,
                      OP_SUBI, OP_MUL};
  endfunction

  function automatic logic is_rtype(input op_t op);
    return op inside {OP_ADD, OP_SUB, OP_MUL};
  endfunction

  function automatic logic [DATA_W-1:0] sext5(
    input logic [I5_MSB:0] v
  );
    return {{(DATA_W-I5_MSB-1){v[I5_MSB]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] sext9(
    input logic [I9_MSB:0] v
  );
    return {{(DATA_W-I9_MSB-1){v[I9_MSB]}}, v};
  endfunction

endpackage

// File: rtl/controle_execucao_if.sv
// Instruction handshake between the upstream
// fetch logic and the issue/execute controller.
interface controle_execucao_if;

  logic                        instr_valid;
  logic [ctrl_pkg::DATA_W-1:0] instr;
  logic                        instr_ready;

  modport master (
    output instr_valid,
    output instr,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr,
    output instr_ready
  );

endinterface

// File: rtl/controle_execucao_banco_registradores.sv
// 16x16 register file: two async reads,
// one sync write, single-cycle clear-all.
module banco_registradores
  import ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [AW-1:0]     ra1,
  input  logic [AW-1:0]     ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  logic [DATA_W-1:0] mem [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NREG; i++)
        mem[i] <= '0;
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  assign rd1 = mem[ra1];
  assign rd2 = mem[ra2];

endmodule

// File: rtl/controle_execucao.sv
// Four-state issue/execute controller in front
// of the external 16-bit signed ALU.
module controle_execucao
  import ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  controle_execucao_if.slave bus,
  output logic [DATA_W-1:0] ula_a,
  output logic [DATA_W-1:0] ula_b,
  output logic [2:0]        ula_param,
  input  logic [DATA_W:0]   ula_s,
  output logic [DATA_W-1:0] result,
  output logic [AW-1:0]     result_rd,
  output logic              ovf,
  output logic              done
);

  state_t            state, state_nx;
  logic [DATA_W-1:0] instr_q;
  logic              ready_q;
  logic              accept;
  op_t               op;
  logic [AW-1:0]     rd, rs1, rs2;
  logic [DATA_W-1:0] rd1, rd2, opnd_b;
  logic              we, clr;

  assign op  = op_t'(instr_q[OP_MSB:OP_LSB]);
  assign rd  = instr_q[RD_MSB:RD_LSB];
  assign rs1 = instr_q[RS1_MSB:RS1_LSB];
  assign rs2 = instr_q[RS2_MSB:RS2_LSB];

  assign bus.instr_ready = ready_q;
  assign accept = bus.instr_valid & ready_q
                & (state == IDLE);

  assign we  = (state == WRITE)
             & (op != OP_CLR) & (op != OP_DISP);
  assign clr = (state == WRITE) & (op == OP_CLR);

  banco_registradores u_banco (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .we    (we),
    .wa    (rd),
    .wd    (result),
    .ra1   (rs1),
    .ra2   (rs2),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (accept) state_nx = DECODE;
      DECODE: state_nx = EXEC;
      EXEC:   state_nx = WRITE;
      WRITE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // LOAD rides on operand B so EXEC can
  // publish it without touching the ALU.
  always_comb begin
    opnd_b = sext5(instr_q[I5_MSB:0]);
    unique case (1'b1)
      is_rtype(op):    opnd_b = rd2;
      op == OP_LOAD:   opnd_b = sext9(instr_q[I9_MSB:0]);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q   <= '0;
      ready_q   <= 1'b0;
      ula_a     <= '0;
      ula_b     <= '0;
      ula_param <= '0;
      result    <= '0;
      result_rd <= '0;
      ovf       <= 1'b0;
      done      <= 1'b0;
    end else begin
      done    <= 1'b0;
      ready_q <= (state_nx == IDLE);
      unique case (state)
        IDLE: if (accept) instr_q <= bus.instr;
        DECODE: begin
          ula_a     <= rd1;
          ula_b     <= opnd_b;
          ula_param <= is_alu(op) ? op : OP_LOAD;
        end
        EXEC: begin
          ula_param <= '0;
          done      <= 1'b1;
          unique case (1'b1)
            op == OP_LOAD: begin
              result    <= ula_b;
              result_rd <= rd;
              ovf       <= 1'b0;
            end
            op == OP_CLR: begin
              result    <= '0;
              result_rd <= '0;
              ovf       <= 1'b0;
            end
            op == OP_DISP: begin
              result    <= ula_a;
              result_rd <= rs1;
              ovf       <= 1'b0;
            end
            default: begin
              result    <= ula_s[DATA_W-1:0];
              result_rd <= rd;
              ovf       <= ula_s[DATA_W]
                         ^ ula_s[DATA_W-1];
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_controle_execucao.sv
// Randomized bench for controle_execucao with an
// integer-arithmetic model of the register machine.
module tb_controle_execucao;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] ula_a, ula_b, result;
  logic [2:0]  ula_param;
  logic [16:0] ula_s;
  logic [3:0]  result_rd;
  logic        ovf, done;

  controle_execucao_if bus ();

  controle_execucao dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .ula_a     (ula_a),
    .ula_b     (ula_b),
    .ula_param (ula_param),
    .ula_s     (ula_s),
    .result    (result),
    .result_rd (result_rd),
    .ovf       (ovf),
    .done      (done)
  );

  always #5 clk = ~clk;

  // external ALU: 17-bit two's-complement result
  int alu_a, alu_b, alu_r;
  always_comb begin
    alu_a = int'($signed(ula_a));
    alu_b = int'($signed(ula_b));
    alu_r = 0;
    case (ula_param)
      3'd1, 3'd2: alu_r = alu_a + alu_b;
      3'd3, 3'd4: alu_r = alu_a - alu_b;
      3'd5:       alu_r = alu_a * alu_b;
      default:    alu_r = 0;
    endcase
    ula_s = alu_r[16:0];
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  int mregs [16];
  logic [15:0] obs_res;
  logic [3:0]  obs_rd;
  logic        obs_ovf;

  task automatic model(input  logic [15:0] w,
                       output logic [15:0] eres,
                       output logic [3:0]  erd,
                       output logic        eovf,
                       output logic [2:0]  epar);
    int op, rd, rs1, rs2, i5, i9, a, b, v;
    logic [31:0] s;
    op  = int'(w[15:13]);
    rd  = int'(w[12:9]);
    rs1 = int'(w[8:5]);
    rs2 = int'(w[4:1]);
    i5  = int'($signed(w[4:0]));
    i9  = int'($signed(w[8:0]));
    a = mregs[rs1];
    b = mregs[rs2];
    v = 0;
    eovf = 1'b0;
    epar = 3'd0;
    erd  = 4'(rd);
    case (op)
      0: v = i9;
      1: v = a + b;
      2: v = a + i5;
      3: v = a - b;
      4: v = a - i5;
      5: v = a * b;
      6: v = 0;
      default: v = a;
    endcase
    eres = 16'(v);
    if (op >= 1 && op <= 4) begin
      epar = 3'(op);
      eovf = (v > 32767) || (v < -32768);
    end else if (op == 5) begin
      // product folded to 17 bits, then sign mismatch
      epar = 3'(op);
      s = 32'(v);
      eovf = s[16] ^ s[15];
    end
    if (op == 6) begin
      erd = 4'd0;
      for (int i = 0; i < 16; i++) mregs[i] = 0;
    end else if (op == 7) begin
      erd = 4'(rs1);
    end else begin
      mregs[rd] = int'($signed(eres));
    end
  endtask

  // entered and left just after a falling edge
  task automatic run_instr(input logic [15:0] w,
                           input bit noisy);
    int t;
    logic [15:0] eres;
    logic [3:0]  erd;
    logic        eovf;
    logic [2:0]  epar;
    t = 0;
    while (bus.instr_ready !== 1'b1 && t < 16) begin
      @(negedge clk);
      t++;
    end
    if (bus.instr_ready !== 1'b1) begin
      chk("ready_wait", 32'(bus.instr_ready), 1);
      return;
    end
    model(w, eres, erd, eovf, epar);
    bus.instr_valid = 1'b1;
    bus.instr = w;
    @(negedge clk);
    if (noisy) bus.instr = 16'($urandom);
    else bus.instr_valid = 1'b0;
    chk("dec_ready", 32'(bus.instr_ready), 0);
    chk("dec_done", 32'(done), 0);
    chk("dec_param", 32'(ula_param), 0);
    @(negedge clk);
    if (noisy) bus.instr = 16'($urandom);
    chk("exe_ready", 32'(bus.instr_ready), 0);
    chk("exe_done", 32'(done), 0);
    chk("exe_param", 32'(ula_param), 32'(epar));
    @(negedge clk);
    if (noisy) bus.instr = 16'($urandom);
    chk("wr_ready", 32'(bus.instr_ready), 0);
    chk("wr_done", 32'(done), 1);
    chk("wr_param", 32'(ula_param), 0);
    chk("wr_result", 32'(result), 32'(eres));
    chk("wr_rd", 32'(result_rd), 32'(erd));
    chk("wr_ovf", 32'(ovf), 32'(eovf));
    obs_res = result;
    obs_rd  = result_rd;
    obs_ovf = ovf;
    @(negedge clk);
    chk("idle_done", 32'(done), 0);
    chk("idle_ready", 32'(bus.instr_ready), 1);
  endtask

  function automatic logic [15:0] e_i9(
    input int op, input int rd, input int imm);
    return {3'(op), 4'(rd), 9'(imm)};
  endfunction

  function automatic logic [15:0] e_r(
    input int op, input int rd,
    input int rs1, input int rs2);
    return {3'(op), 4'(rd), 4'(rs1), 4'(rs2), 1'b0};
  endfunction

  function automatic logic [15:0] e_i5(
    input int op, input int rd,
    input int rs1, input int imm);
    return {3'(op), 4'(rd), 4'(rs1), 5'(imm)};
  endfunction

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ready"}, 32'(bus.instr_ready), 0);
    chk({tag, "_a"}, 32'(ula_a), 0);
    chk({tag, "_b"}, 32'(ula_b), 0);
    chk({tag, "_param"}, 32'(ula_param), 0);
    chk({tag, "_result"}, 32'(result), 0);
    chk({tag, "_rd"}, 32'(result_rd), 0);
    chk({tag, "_ovf"}, 32'(ovf), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] w;
    int op;
    for (int i = 0; i < 16; i++) mregs[i] = 0;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    repeat (3) @(negedge clk);
    chk_zero_outputs("rst");
    rst_n = 1'b1;

    // LOAD/LOAD/ADD/DISP back to back
    run_instr(e_i9(0, 1, 5), 1'b0);
    run_instr(e_i9(0, 2, -3), 1'b0);
    run_instr(e_r(1, 3, 1, 2), 1'b0);
    run_instr(e_r(7, 0, 3, 0), 1'b0);
    chk("t1_disp", 32'(obs_res), 32'h0002);
    chk("t1_disp_rd", 32'(obs_rd), 3);

    run_instr(e_i9(0, 1, 100), 1'b0);
    run_instr(e_i5(4, 4, 1, -16), 1'b0);
    chk("t2_subi", 32'(obs_res), 116);

    run_instr(e_i9(0, 1, 255), 1'b0);
    run_instr(e_r(5, 5, 1, 1), 1'b0);
    chk("t3_mul", 32'(obs_res), 32'hFE01);
    chk("t3_ovf", 32'(obs_ovf), 1);

    run_instr(e_i9(0, 6, 255), 1'b0);
    run_instr(16'hC000, 1'b0);
    run_instr(e_r(7, 0, 6, 0), 1'b0);
    chk("t4_disp", 32'(obs_res), 0);
    chk("t4_disp_rd", 32'(obs_rd), 6);

    // valid held high, garbage while busy
    for (int k = 0; k < 60; k++) begin
      w = 16'($urandom);
      run_instr(w, 1'b1);
    end
    bus.instr_valid = 1'b0;

    for (int k = 0; k < 160; k++) begin
      op = $urandom_range(0, 7);
      if (op == 6 && $urandom_range(0, 3) != 0) op = 1;
      w = {3'(op), 13'($urandom)};
      run_instr(w, $urandom_range(0, 1) == 1);
      bus.instr_valid = 1'b0;
    end

    for (int r = 0; r < 16; r++)
      run_instr(e_r(7, 0, r, 0), 1'b0);

    // reset lands during EXEC of ADD r7
    run_instr(e_i9(0, 1, 7), 1'b0);
    run_instr(e_i9(0, 2, 9), 1'b0);
    bus.instr_valid = 1'b1;
    bus.instr = e_r(1, 7, 1, 2);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    chk("mid_param", 32'(ula_param), 1);
    #2 rst_n = 1'b0;
    #1 chk_zero_outputs("mid");
    @(negedge clk);
    chk("mid_done", 32'(done), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) mregs[i] = 0;
    @(negedge clk);
    chk("post_done", 32'(done), 0);
    run_instr(e_r(7, 0, 7, 0), 1'b0);
    chk("post_r7", 32'(obs_res), 0);
    run_instr(e_r(7, 0, 1, 0), 1'b0);
    chk("post_r1", 32'(obs_res), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
